// File: rtl/memory_access_unit.sv
// memory_access_unit: load/store initiator between the MEM stage and a word-wide memory.
// Byte/half/word loads and stores become aligned word accesses. Sub-word stores use
// read-modify-write. Load data is extracted and sign- or zero-extended.
// Optional feature macro: MAU_ROM_GUARD_EN. When defined, stores into the ROM region
// (address[31:ROM_ADDR_BITS] == 0) fault without touching memory.
module memory_access_unit #(
  parameter int ROM_ADDR_BITS = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic        busy,
  output logic        done,
  output logic [31:0] loadData,
  output logic        misaligned,
  output logic        accessFault,
  output logic [31:0] memAddress,
  output logic        memReadEnable,
  output logic        memWriteEnable,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData
);

`ifdef MAU_ROM_GUARD_EN
  localparam logic ROM_GUARD = 1'b1;
`else
  localparam logic ROM_GUARD = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;

  logic        is_store_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r;
  logic [31:0] store_data_r;
  logic [31:0] rdata_r;
  logic [31:0] load_data_r;
  logic        misaligned_r;
  logic        fault_r;

  logic        legal_s;
  logic        align_err_s;
  logic        req_misaligned_s;
  logic        rom_region_s;
  logic        req_fault_s;

  // Pick the addressed lane of a word and extend it according to the load size.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (f3)
      3'b000:  extract_load = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  extract_load = {24'd0, shifted[7:0]};
      3'b001:  extract_load = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  extract_load = {16'd0, shifted[15:0]};
      default: extract_load = word;
    endcase
  endfunction

  // Replace the addressed byte/half lane of the captured word; full words pass through.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] sdata,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] result;
    result = word;
    case (f3)
      3'b000: result[{off, 3'b000} +: 8] = sdata[7:0];
      3'b001: begin
        if (off[1]) begin
          result[31:16] = sdata[15:0];
        end else begin
          result[15:0] = sdata[15:0];
        end
      end
      default: result = sdata;
    endcase
    merge_store = result;
  endfunction

  // Classify the incoming request: legal size code, alignment and ROM-region store.
  always_comb begin
    legal_s = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal_s = 1'b1;
      3'b100, 3'b101:         legal_s = ~isStore;
      default:                legal_s = 1'b0;
    endcase
    align_err_s = 1'b0;
    case (funct3[1:0])
      2'b01:   align_err_s = address[0];
      2'b10:   align_err_s = |address[1:0];
      default: align_err_s = 1'b0;
    endcase
    req_misaligned_s = ~legal_s | align_err_s;
    rom_region_s     = (address >> ROM_ADDR_BITS) == 32'd0;
    req_fault_s      = ROM_GUARD & isStore & ~req_misaligned_s & rom_region_s;
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: faults skip memory, SW writes directly, SB/SH read first.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (req_misaligned_s || req_fault_s) begin
            next_state_s = S_DONE;
          end else if (!isStore) begin
            next_state_s = S_READ;
          end else if (funct3 == 3'b010) begin
            next_state_s = S_WRITE;
          end else begin
            next_state_s = S_READ;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_READ: begin
        if (is_store_r) begin
          next_state_s = S_WRITE;
        end else begin
          next_state_s = S_DONE;
        end
      end
      S_WRITE: next_state_s = S_DONE;
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Request latch, read-word capture and load result update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_store_r   <= 1'b0;
      funct3_r     <= 3'd0;
      addr_r       <= 32'd0;
      store_data_r <= 32'd0;
      rdata_r      <= 32'd0;
      load_data_r  <= 32'd0;
      misaligned_r <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      if (state_r == S_IDLE && start) begin
        is_store_r   <= isStore;
        funct3_r     <= funct3;
        addr_r       <= address;
        store_data_r <= storeData;
        misaligned_r <= req_misaligned_s;
        fault_r      <= req_fault_s;
      end
      if (state_r == S_READ) begin
        rdata_r <= memReadData;
        if (!is_store_r) begin
          load_data_r <= extract_load(memReadData, funct3_r, addr_r[1:0]);
        end
      end
    end
  end

  // Output decode from the current state; bus signals are quiet outside READ/WRITE.
  always_comb begin
    busy           = (state_r != S_IDLE);
    done           = (state_r == S_DONE);
    memReadEnable  = (state_r == S_READ);
    memWriteEnable = (state_r == S_WRITE);
    loadData       = load_data_r;
    misaligned     = done & misaligned_r;
    accessFault    = done & fault_r & ROM_GUARD;
    if (state_r == S_READ || state_r == S_WRITE) begin
      memAddress = {addr_r[31:2], 2'b00};
    end else begin
      memAddress = 32'd0;
    end
    if (state_r == S_WRITE) begin
      memWriteData = merge_store(rdata_r, store_data_r, funct3_r, addr_r[1:0]);
    end else begin
      memWriteData = 32'd0;
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: directed vector table, hand-written
// multi-cycle sequences and randomized requests checked against a byte-level model.
module tb_memory_access_unit;

`ifdef MAU_ROM_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        isStore;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] storeData;
  logic        busy;
  logic        done;
  logic [31:0] loadData;
  logic        misaligned;
  logic        accessFault;
  logic [31:0] memAddress;
  logic        memReadEnable;
  logic        memWriteEnable;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;
  logic [31:0] mem_word;

  int total;
  int bad;
  logic [31:0] model_load;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] word;
    int          lat;
    logic [31:0] load;
    logic        mis;
    logic        fault;
    int          nrd;
    int          nwr;
    logic [31:0] wdata;
  } vec_t;

  vec_t tbl[16];

  memory_access_unit #(.ROM_ADDR_BITS(11)) dut (
    .clk(clk), .reset(reset), .start(start), .isStore(isStore), .funct3(funct3),
    .address(address), .storeData(storeData), .busy(busy), .done(done),
    .loadData(loadData), .misaligned(misaligned), .accessFault(accessFault),
    .memAddress(memAddress), .memReadEnable(memReadEnable),
    .memWriteEnable(memWriteEnable), .memWriteData(memWriteData),
    .memReadData(memReadData)
  );

  // Memory responder: the current op's word, garbage when not reading.
  assign memReadData = memReadEnable ? mem_word : 32'hA5A5_5A5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model from size/lane arithmetic on bytes.
  function automatic vec_t model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [31:0] word,
                                 input logic [31:0] prev_load);
    vec_t v;
    int size;
    int off;
    bit legal;
    longint val;
    logic [7:0] b[4];
    v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.word = word;
    v.load = prev_load; v.nrd = 0; v.nwr = 0; v.wdata = 32'd0; v.fault = 1'b0;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    off = int'(addr % 32'd4);
    v.mis = !legal || (addr % size != 0);
    v.fault = GUARD && !v.mis && st && (addr < 32'd2048);
    if (v.mis || v.fault) begin
      v.lat = 1;
    end else if (!st) begin
      v.lat = 2; v.nrd = 1;
      val = 0;
      for (int k = 0; k < size; k++)
        val += longint'((word >> (8 * (off + k))) & 32'hFF) << (8 * k);
      if (!f3[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
        val -= (longint'(1) << (8 * size));
      v.load = val[31:0];
    end else if (size == 4) begin
      v.lat = 2; v.nwr = 1; v.wdata = sdata;
    end else begin
      v.lat = 3; v.nrd = 1; v.nwr = 1;
      for (int i = 0; i < 4; i++) b[i] = word[8 * i +: 8];
      for (int k = 0; k < size; k++) b[off + k] = sdata[8 * k +: 8];
      v.wdata = {b[3], b[2], b[1], b[0]};
    end
    return v;
  endfunction

  // Issue one request and check every observable against e.
  task automatic run_and_check(input vec_t e, input string name);
    int lat = 0, nrd = 0, nwr = 0;
    logic [31:0] raddr = 32'd0, waddr = 32'd0, wdata = 32'd0;
    logic mis_o = 1'b0, fault_o = 1'b0, busy_o = 1'b0, addr_ok = 1'b1;
    @(negedge clk);
    isStore = e.st; funct3 = e.f3; address = e.addr; storeData = e.sdata;
    mem_word = e.word; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (memAddress[1:0] != 2'b00) addr_ok = 1'b0;
      if (memReadEnable) begin nrd++; raddr = memAddress; end
      if (memWriteEnable) begin nwr++; waddr = memAddress; wdata = memWriteData; end
      if (done) begin
        lat = k; mis_o = misaligned; fault_o = accessFault; busy_o = busy;
        break;
      end
    end
    check({name, " latency"}, 32'(lat), 32'(e.lat));
    check({name, " loadData"}, loadData, e.load);
    check({name, " misaligned"}, {31'd0, mis_o}, {31'd0, e.mis});
    check({name, " accessFault"}, {31'd0, fault_o}, {31'd0, e.fault});
    check({name, " busy@done"}, {31'd0, busy_o}, 32'd1);
    check({name, " reads"}, 32'(nrd), 32'(e.nrd));
    check({name, " writes"}, 32'(nwr), 32'(e.nwr));
    check({name, " addr aligned"}, {31'd0, addr_ok}, 32'd1);
    if (e.nrd > 0) check({name, " read addr"}, raddr, e.addr & 32'hFFFF_FFFC);
    if (e.nwr > 0) begin
      check({name, " write addr"}, waddr, e.addr & 32'hFFFF_FFFC);
      check({name, " write data"}, wdata, e.wdata);
    end
    model_load = e.load;
  endtask

  initial begin
    int dones, reads;
    logic [31:0] bases[6];
    vec_t r;
    total = 0; bad = 0; model_load = 32'd0;
    start = 1'b0; isStore = 1'b0; funct3 = 3'd0; address = 32'd0; storeData = 32'd0;
    mem_word = 32'd0;
    reset = 1'b1;

    // Directed vectors: {st, f3, addr, sdata, word, lat, load, mis, fault, nrd, nwr, wdata}
    tbl[0]  = '{1'b0, 3'd2, 32'h0000_0804, 32'd0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 1'b0, 1'b0, 1, 0, 32'd0};
    tbl[1]  = '{1'b0, 3'd0, 32'h0000_0803, 32'd0, 32'h8012_3456, 2, 32'hFFFF_FF80, 1'b0, 1'b0, 1, 0, 32'd0};
    tbl[2]  = '{1'b0, 3'd4, 32'h0000_0803, 32'd0, 32'h8012_3456, 2, 32'h0000_0080, 1'b0, 1'b0, 1, 0, 32'd0};
    tbl[3]  = '{1'b1, 3'd0, 32'h0000_1001, 32'h0000_00AB, 32'h1122_3344, 3, 32'h0000_0080, 1'b0, 1'b0, 1, 1, 32'h1122_AB44};
    tbl[4]  = '{1'b0, 3'd1, 32'h0000_1001, 32'd0, 32'h1234_5678, 1, 32'h0000_0080, 1'b1, 1'b0, 0, 0, 32'd0};
    tbl[5]  = GUARD ? '{1'b1, 3'd2, 32'h0000_0004, 32'h1234_5678, 32'd0, 1, 32'h0000_0080, 1'b0, 1'b1, 0, 0, 32'd0}
                    : '{1'b1, 3'd2, 32'h0000_0004, 32'h1234_5678, 32'd0, 2, 32'h0000_0080, 1'b0, 1'b0, 0, 1, 32'h1234_5678};
    tbl[6]  = '{1'b0, 3'd1, 32'h0000_1002, 32'd0, 32'h8001_7FFF, 2, 32'hFFFF_8001, 1'b0, 1'b0, 1, 0, 32'd0};
    tbl[7]  = '{1'b1, 3'd1, 32'h0000_2002, 32'h1234_BEEF, 32'h1122_3344, 3, 32'hFFFF_8001, 1'b0, 1'b0, 1, 1, 32'hBEEF_3344};
    tbl[8]  = '{1'b0, 3'd3, 32'h0000_0000, 32'd0, 32'h1111_1111, 1, 32'hFFFF_8001, 1'b1, 1'b0, 0, 0, 32'd0};
    tbl[9]  = '{1'b1, 3'd4, 32'h0000_2000, 32'h5555_5555, 32'h1111_1111, 1, 32'hFFFF_8001, 1'b1, 1'b0, 0, 0, 32'd0};
    tbl[10] = '{1'b0, 3'd2, 32'h0000_2001, 32'd0, 32'h1111_1111, 1, 32'hFFFF_8001, 1'b1, 1'b0, 0, 0, 32'd0};
    tbl[11] = '{1'b0, 3'd0, 32'h0000_2000, 32'd0, 32'h0000_007F, 2, 32'h0000_007F, 1'b0, 1'b0, 1, 0, 32'd0};
    tbl[12] = '{1'b0, 3'd5, 32'h0000_2002, 32'd0, 32'h8001_7FFF, 2, 32'h0000_8001, 1'b0, 1'b0, 1, 0, 32'd0};
    tbl[13] = GUARD ? '{1'b1, 3'd0, 32'h0000_0012, 32'h0000_0011, 32'hAABB_CCDD, 1, 32'h0000_8001, 1'b0, 1'b1, 0, 0, 32'd0}
                    : '{1'b1, 3'd0, 32'h0000_0012, 32'h0000_0011, 32'hAABB_CCDD, 3, 32'h0000_8001, 1'b0, 1'b0, 1, 1, 32'hAA11_CCDD};
    tbl[14] = '{1'b0, 3'd2, 32'h0000_07FC, 32'd0, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, 1'b0, 1'b0, 1, 0, 32'd0};
    tbl[15] = '{1'b1, 3'd1, 32'h0000_0003, 32'h0000_7777, 32'd0, 1, 32'hCAFE_F00D, 1'b1, 1'b0, 0, 0, 32'd0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset loadData", loadData, 32'd0);
    check("reset memAddress", memAddress, 32'd0);
    check("reset enables", {30'd0, memReadEnable, memWriteEnable}, 32'd0);
    check("reset memWriteData", memWriteData, 32'd0);
    check("reset flags", {30'd0, misaligned, accessFault}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++)
      run_and_check(tbl[i], $sformatf("vec%0d", i));

    // Start pulses while busy must be ignored.
    @(negedge clk);
    isStore = 1'b0; funct3 = 3'd2; address = 32'h0000_2000; mem_word = 32'h1357_9BDF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    dones = 0; reads = 0;
    if (memReadEnable) reads++;
    isStore = 1'b1; funct3 = 3'd2; address = 32'h0000_3000; start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) dones++;
      if (memReadEnable) reads++;
    end
    start = 1'b0;
    @(negedge clk);
    check("busy-start dones", 32'(dones), 32'd1);
    check("busy-start reads", 32'(reads), 32'd1);
    check("busy-start loadData", loadData, 32'h1357_9BDF);
    model_load = 32'h1357_9BDF;

    // Randomized requests against the model.
    bases[0] = 32'h0000_0010; bases[1] = 32'h0000_07F0; bases[2] = 32'h0000_0800;
    bases[3] = 32'h0000_1000; bases[4] = 32'h8000_0000; bases[5] = 32'hFFFF_FFF0;
    for (int n = 0; n < 200; n++) begin
      r = model(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                bases[$urandom_range(0, 5)] + 32'($urandom_range(0, 15)),
                $urandom, $urandom, model_load);
      run_and_check(r, $sformatf("rnd%0d", n));
    end

    // Reset during the WRITE of an SW aborts with no done pulse.
    @(negedge clk);
    isStore = 1'b1; funct3 = 3'd2; address = 32'h0000_3000; storeData = 32'h0000_0055; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("abort in WRITE", {31'd0, memWriteEnable}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort writeEnable", {31'd0, memWriteEnable}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort memAddress", memAddress, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done || memWriteEnable) dones++;
    end
    check("abort no done", 32'(dones), 32'd0);
    check("abort loadData", loadData, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
